// File: rtl/fft_iter_pkg.sv
// Shared types for the iterative FFT frame scheduler.
// State encodings, RAM owner codes and a bit-reverse helper.
package fft_iter_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_LOAD    = 2'd1,
    SCHED_COMPUTE = 2'd2,
    SCHED_UNLOAD  = 2'd3
  } sched_state_e;

  localparam logic [1:0] RAM_SEL_NONE   = 2'b00;
  localparam logic [1:0] RAM_SEL_LOAD   = 2'b01;
  localparam logic [1:0] RAM_SEL_CORE   = 2'b10;
  localparam logic [1:0] RAM_SEL_UNLOAD = 2'b11;

  localparam int unsigned BITREV_MAX_W = 16;

  // Reverse the low w bits of v; bits at and above w come back as 0.
  function automatic logic [15:0] bit_rev(
    input logic [15:0] v,
    input int unsigned w
  );
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[4'(i)] = v[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_iter_frame_scheduler_unloader.sv
// UNLOAD-phase stream handshake: read counter, output counter and
// the OUT_VALID register sitting in front of the one-cycle RAM read.
module fft_stream_unloader
  import fft_iter_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int AddrWL   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              out_ready_i,
  output logic              rd_en_o,
  output logic [AddrWL-1:0] addr_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              done_o
);

  localparam int CW = AddrWL + 1;

  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          valid_q, valid_d;
  logic          accept;
  logic          at_last;

  assign at_last = (out_cnt_q == CW'(N_POINTS - 1));
  assign accept  = en_i & valid_q & out_ready_i;
  assign rd_en_o = en_i & (rd_cnt_q < CW'(N_POINTS))
                 & (~valid_q | out_ready_i);
  assign addr_o  = rd_cnt_q[AddrWL-1:0];
  assign valid_o = valid_q;
  assign last_o  = valid_q & at_last;
  assign done_o  = accept & at_last;

  // Next-state: a new read refills the output slot, a bare accept drains it.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    valid_d   = valid_q;
    if (clear_i) begin
      rd_cnt_d  = '0;
      out_cnt_d = '0;
      valid_d   = 1'b0;
    end else if (en_i) begin
      if (rd_en_o) rd_cnt_d = rd_cnt_q + CW'(1);
      if (accept) out_cnt_d = out_cnt_q + CW'(1);
      if (rd_en_o) valid_d = 1'b1;
      else if (out_ready_i) valid_d = 1'b0;
    end
  end

  // Handshake state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/fft_iter_frame_scheduler.sv
// Frame sequencer LOAD -> COMPUTE -> UNLOAD and sample-RAM owner select.
// Define FFT_SCHED_BITREV_LOAD_EN to write input samples bit-reversed.
module fft_iter_frame_scheduler
  import fft_iter_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int AddrWL   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              FRAME_START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              IN_WE,
  output logic [AddrWL-1:0] IN_ADDR,
  output logic              CORE_START,
  input  logic              CORE_DONE,
  output logic              OUT_RD_EN,
  output logic [AddrWL-1:0] OUT_ADDR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic [1:0]        RAM_SEL,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int CW = AddrWL + 1;

  sched_state_e  state_q;
  logic [CW-1:0] wr_cnt_q;
  logic          core_start_q;
  logic [1:0]    ram_sel_q;
  logic          busy_q;
  logic          in_acc;
  logic          wr_last;
  logic          unl_en;
  logic          unl_clr;
  logic          unl_done;

  assign IN_READY   = EN & (state_q == SCHED_LOAD);
  assign in_acc     = IN_VALID & IN_READY;
  assign IN_WE      = in_acc;
  assign wr_last    = (wr_cnt_q == CW'(N_POINTS - 1));
  assign unl_en     = EN & (state_q == SCHED_UNLOAD);
  assign unl_clr    = EN & (state_q == SCHED_COMPUTE) & CORE_DONE;
  assign CORE_START = core_start_q;
  assign RAM_SEL    = ram_sel_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = unl_done;

`ifdef FFT_SCHED_BITREV_LOAD_EN
  logic [15:0] rev_full;
  assign rev_full = bit_rev(16'(wr_cnt_q[AddrWL-1:0]), AddrWL);
  assign IN_ADDR  = rev_full[AddrWL-1:0];
`else
  assign IN_ADDR  = wr_cnt_q[AddrWL-1:0];
`endif

  fft_stream_unloader #(
    .N_POINTS (N_POINTS),
    .AddrWL   (AddrWL)
  ) u_unl (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (unl_en),
    .clear_i     (unl_clr),
    .out_ready_i (OUT_READY),
    .rd_en_o     (OUT_RD_EN),
    .addr_o      (OUT_ADDR),
    .valid_o     (OUT_VALID),
    .last_o      (OUT_LAST),
    .done_o      (unl_done)
  );

  // Phase FSM with registered RAM owner, busy flag and core start pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= SCHED_IDLE;
      wr_cnt_q     <= '0;
      core_start_q <= 1'b0;
      ram_sel_q    <= RAM_SEL_NONE;
      busy_q       <= 1'b0;
    end else if (EN) begin
      core_start_q <= 1'b0;
      unique case (state_q)
        SCHED_IDLE: begin
          if (FRAME_START) begin
            state_q   <= SCHED_LOAD;
            wr_cnt_q  <= '0;
            ram_sel_q <= RAM_SEL_LOAD;
            busy_q    <= 1'b1;
          end
        end
        SCHED_LOAD: begin
          if (in_acc) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
            if (wr_last) begin
              state_q      <= SCHED_COMPUTE;
              ram_sel_q    <= RAM_SEL_CORE;
              core_start_q <= 1'b1;
            end
          end
        end
        SCHED_COMPUTE: begin
          if (CORE_DONE) begin
            state_q   <= SCHED_UNLOAD;
            ram_sel_q <= RAM_SEL_UNLOAD;
          end
        end
        SCHED_UNLOAD: begin
          if (unl_done) begin
            state_q   <= SCHED_IDLE;
            ram_sel_q <= RAM_SEL_NONE;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_frame_scheduler.sv
// Randomized frame-level bench for fft_iter_frame_scheduler with a
// phase-level reference model and a RAM/data scoreboard.
module tb_fft_iter_frame_scheduler;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          FRAME_START;
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_WE;
  logic [AW-1:0] IN_ADDR;
  logic          CORE_START;
  logic          CORE_DONE;
  logic          OUT_RD_EN;
  logic [AW-1:0] OUT_ADDR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OUT_LAST;
  logic [1:0]    RAM_SEL;
  logic          BUSY;
  logic          FRAME_DONE;

  always #5 CLK = ~CLK;

  fft_iter_frame_scheduler #(.N_POINTS(N), .AddrWL(AW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FRAME_START(FRAME_START),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_WE(IN_WE),
    .IN_ADDR(IN_ADDR), .CORE_START(CORE_START), .CORE_DONE(CORE_DONE),
    .OUT_RD_EN(OUT_RD_EN), .OUT_ADDR(OUT_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .RAM_SEL(RAM_SEL),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 load, 2 compute, 3 unload
  int ph, nin, nrd, nout;
  bit mv, mstart;

  int ram [N];
  int inq[$];
  int inaddr_q[$];
  int rdata;
  int sb_out;

  int c_we, c_start, c_acc, c_done, c_rd, c_valid, c_last, c_quiet;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int map_in(input int k);
`ifdef FFT_SCHED_BITREV_LOAD_EN
    return rev(k);
`else
    return k;
`endif
  endfunction

  // One cycle: compare at negedge, update model, return at posedge+1.
  task automatic tick();
    int  e_rd;
    bit  acc;
    int  j;
    @(negedge CLK);
    if (RST) begin
      ph = 0; nin = 0; nrd = 0; nout = 0; mv = 0; mstart = 0;
      inq.delete(); inaddr_q.delete(); sb_out = 0;
    end
    e_rd = (EN && ph == 3 && nrd < N && (!mv || OUT_READY)) ? 1 : 0;
    acc  = EN && ph == 3 && mv && OUT_READY;
    chk("busy",       int'(BUSY),       int'(ph != 0));
    chk("ram_sel",    int'(RAM_SEL),    ph);
    chk("in_ready",   int'(IN_READY),   int'(EN && ph == 1));
    chk("in_we",      int'(IN_WE),      int'(EN && ph == 1 && IN_VALID));
    chk("in_addr",    int'(IN_ADDR),    map_in(nin % N));
    chk("core_start", int'(CORE_START), int'(mstart));
    chk("out_rd_en",  int'(OUT_RD_EN),  e_rd);
    chk("out_addr",   int'(OUT_ADDR),   nrd % N);
    chk("out_valid",  int'(OUT_VALID),  int'(mv));
    chk("out_last",   int'(OUT_LAST),   int'(mv && nout == N - 1));
    chk("frame_done", int'(FRAME_DONE), int'(acc && nout == N - 1));
    // scoreboard driven by what the DUT actually does on the RAM ports
    if (IN_WE) begin
      j = int'($urandom_range(65535));
      ram[IN_ADDR] = j;
      inq.push_back(j);
      inaddr_q.push_back(int'(IN_ADDR));
      c_we++;
    end
    if (OUT_VALID && OUT_READY && EN) begin
      j = sb_out;
      chk("sb_in_range", int'(j < inq.size()), 1);
      if (j < inq.size()) chk("data", rdata, inq[map_in(j)]);
      sb_out++;
      c_acc++;
    end
    if (OUT_RD_EN) begin
      rdata = ram[OUT_ADDR];
      c_rd++;
    end
    c_start += int'(CORE_START);
    c_done  += int'(FRAME_DONE);
    c_valid += int'(OUT_VALID);
    c_last  += int'(OUT_LAST);
    if (IN_READY || OUT_RD_EN) c_quiet++;
    if (!RST && EN) begin
      mstart = 0;
      case (ph)
        0: if (FRAME_START) begin
          ph = 1; nin = 0;
          inq.delete(); inaddr_q.delete(); sb_out = 0;
        end
        1: if (IN_VALID) begin
          if (nin == N - 1) begin ph = 2; mstart = 1; end
          nin++;
        end
        2: if (CORE_DONE) begin
          ph = 3; nrd = 0; nout = 0; mv = 0;
        end
        default: begin
          if (acc && nout == N - 1) ph = 0;
          nrd += e_rd;
          if (acc) nout++;
          if (e_rd == 1) mv = 1;
          else if (OUT_READY) mv = 0;
        end
      endcase
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input int vprob, input int rmode, input int enprob,
                           input int cdelay, input bit fs_mid, input bit en_gap);
    int w0, s0, a0, d0, r0, v0, l0, q0, wb, n;
    bit gap_done;
    w0 = c_we; s0 = c_start; a0 = c_acc; d0 = c_done;
    r0 = c_rd; v0 = c_valid; l0 = c_last;
    gap_done = 0;
    EN = 1; FRAME_START = 1; tick();
    FRAME_START = 0;
    n = 0;
    while (c_we - w0 < N && n < 3000) begin
      if (en_gap && !gap_done && c_we - w0 == 12) begin
        EN = 0; IN_VALID = 1; wb = c_we;
        repeat (5) tick();
        chk("en_gap_frozen", c_we - wb, 0);
        gap_done = 1;
      end else begin
        EN = ($urandom_range(99) < enprob);
        IN_VALID = ($urandom_range(99) < vprob);
        tick();
        n++;
      end
    end
    chk("load_count", c_we - w0, N);
    if (vprob == 100 && enprob == 100 && !en_gap) chk("load_cycles", n, N);
    IN_VALID = 0; EN = 1;
    q0 = c_quiet;
    for (int k = 0; k < cdelay; k++) begin
      FRAME_START = fs_mid && (k == cdelay / 2);
      tick();
    end
    FRAME_START = 0;
    chk("compute_quiet", c_quiet - q0, 0);
    chk("busy_compute", int'(BUSY), 1);
    CORE_DONE = 1; tick();
    CORE_DONE = 0;
    n = 0;
    while (c_done - d0 < 1 && n < 3000) begin
      case (rmode)
        0: OUT_READY = 1;
        1: OUT_READY = (n % 4 == 0) || (n % 4 == 3);
        default: OUT_READY = ($urandom_range(99) < 60);
      endcase
      EN = ($urandom_range(99) < enprob);
      tick();
      n++;
    end
    OUT_READY = 0; EN = 1;
    chk("frame_done_count", c_done - d0, 1);
    chk("accept_count", c_acc - a0, N);
    chk("read_count", c_rd - r0, N);
    chk("start_pulses", c_start - s0, 1);
    if (rmode == 0 && enprob == 100) begin
      chk("valid_cycles", c_valid - v0, N);
      chk("last_cycles", c_last - l0, 1);
      chk("unload_cycles", n, N + 1);
    end
    tick();
    chk("busy_after", int'(BUSY), 0);
  endtask

  initial begin
    RST = 1; EN = 0; FRAME_START = 0; IN_VALID = 0;
    CORE_DONE = 0; OUT_READY = 0;
    c_we = 0; c_start = 0; c_acc = 0; c_done = 0;
    c_rd = 0; c_valid = 0; c_last = 0; c_quiet = 0;
    rdata = 0; sb_out = 0;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ram_sel", int'(RAM_SEL), 0);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_core_start", int'(CORE_START), 0);
    repeat (3) tick();
    RST = 0;
    tick();

    // abort mid-LOAD with an asynchronous reset
    EN = 1; FRAME_START = 1; tick();
    FRAME_START = 0; IN_VALID = 1;
    repeat (10) tick();
    IN_VALID = 0;
    chk("pre_abort_busy", int'(BUSY), 1);
    chk("pre_abort_in_addr", int'(IN_ADDR), map_in(10));
    #2 RST = 1;
    #1;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_ram_sel", int'(RAM_SEL), 0);
    chk("abort_in_ready", int'(IN_READY), 0);
    tick();
    RST = 0;
    tick();

    // back-to-back load, long compute, full-rate unload
    run_frame(100, 0, 100, 200, 0, 0);
    chk("inaddr_n", inaddr_q.size(), N);
    if (inaddr_q.size() == N) begin
      chk("inaddr_0", inaddr_q[0], 0);
`ifdef FFT_SCHED_BITREV_LOAD_EN
      chk("inaddr_1", inaddr_q[1], 16);
`else
      chk("inaddr_1", inaddr_q[1], 1);
`endif
      chk("inaddr_31", inaddr_q[31], 31);
    end

    // EN gap mid-load, FRAME_START during compute, 1,0,0,1 ready pattern
    run_frame(100, 1, 100, 6, 1, 0);
    run_frame(100, 1, 100, 6, 1, 1);

    // randomized traffic
    for (int f = 0; f < 5; f++)
      run_frame(70, 2, 80, int'($urandom_range(20)), 1'($urandom_range(1)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
